// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks every register index through the register file's two combinational
// read ports (even index on port 1, odd index on port 2) and streams the
// captured words out one per beat on a valid/ready interface, tagged with
// the register index. A single done pulse marks the end of a complete dump.

module regfile_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] read_reg1,
  output logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_SEND0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Pair counter value of the final pair (NUM_REGS-2 / NUM_REGS-1).
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_REGS / 2 - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [ADDR_WIDTH-1:0] r_read_reg1;
  logic [ADDR_WIDTH-1:0] r_read_reg2;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_index;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_done;

  logic w_accept;

  assign w_accept  = r_out_valid & out_ready;

  assign read_reg1 = r_read_reg1;
  assign read_reg2 = r_read_reg2;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Dump sequencer: address pairs, capture read data, stream two beats per pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_read_reg1 <= '0;
      r_read_reg2 <= '0;
      r_buf1      <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= ST_READ;
            r_busy      <= 1'b1;
            r_k         <= '0;
            r_read_reg1 <= ADDR_WIDTH'(0);
            r_read_reg2 <= ADDR_WIDTH'(1);
          end
        end
        ST_READ: begin
          // The output data register doubles as the even-word capture buffer;
          // the odd word waits in r_buf1 until the first beat is accepted.
          r_out_data  <= read_data1;
          r_buf1      <= read_data2;
          r_out_index <= r_read_reg1;
          r_out_valid <= 1'b1;
          r_state     <= ST_SEND0;
        end
        ST_SEND0: begin
          if (w_accept) begin
            r_out_data  <= r_buf1;
            r_out_index <= r_read_reg2;
            r_state     <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (r_k == LAST_K) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_k         <= r_k + ADDR_WIDTH'(1);
              r_read_reg1 <= r_read_reg1 + ADDR_WIDTH'(2);
              r_read_reg2 <= r_read_reg2 + ADDR_WIDTH'(2);
              r_state     <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: a 32-entry register file model feeds a
// default-size instance, and a 4-entry model feeds a NUM_REGS=4 instance.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_valid;
  logic        out_ready;
  logic        busy, done;

  logic        start4;
  logic [4:0]  read_reg1_4, read_reg2_4;
  logic [31:0] read_data1_4, read_data2_4;
  logic [31:0] out_data_4;
  logic [4:0]  out_index_4;
  logic        out_valid_4;
  logic        out_ready_4;
  logic        busy_4, done_4;

  logic [31:0] rf  [32];
  logic [31:0] rf4 [4];
  logic [31:0] exp_data [32];

  int total = 0;
  int bad   = 0;

  assign read_data1   = rf[read_reg1];
  assign read_data2   = rf[read_reg2];
  assign read_data1_4 = rf4[read_reg1_4[1:0]];
  assign read_data2_4 = rf4[read_reg2_4[1:0]];

  regfile_dump_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .read_reg1(read_reg1_4), .read_reg2(read_reg2_4),
    .read_data1(read_data1_4), .read_data2(read_data2_4),
    .out_data(out_data_4), .out_index(out_index_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .busy(busy_4), .done(done_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp();
    for (int i = 0; i < 32; i++) exp_data[i] = rf[i];
  endtask

  // One full dump on the 32-entry instance.
  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready.
  // spam: pulse start in SEND0/SEND1 and in the done cycle.
  // inject: write 0xDEADBEEF to register 5 on the negedge inside READ of pair (4,5).
  task automatic do_dump(input int mode, input bit spam, input bit inject);
    int c, beats, stalls;
    bit fin, pv, pacc, injected;
    logic [31:0] pd;
    logic [4:0]  pidx;
    c = 0; beats = 0; stalls = 0; fin = 0; pv = 0; pacc = 0; injected = 0;
    pd = 32'd0; pidx = 5'd0;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    for (int n = 0; n < 400 && !fin; n++) begin
      if (c == 1) begin
        check("first_busy", {31'd0, busy}, 32'd1);
        check("first_rr1", {27'd0, read_reg1}, 32'd0);
        check("first_rr2", {27'd0, read_reg2}, 32'd1);
      end
      if (done) begin
        check("done_beats", beats, 32);
        check("done_cycle", c, 1 + 48 + stalls);
        check("done_valid", {31'd0, out_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        fin = 1;
        start = spam ? 1'b1 : 1'b0;
      end else begin
        check("busy_high", {31'd0, busy}, 32'd1);
        if (out_valid) begin
          if (pv && !pacc) begin
            check("stall_data", out_data, pd);
            check("stall_index", {27'd0, out_index}, {27'd0, pidx});
          end
          if (beats < 32) begin
            check("beat_index", {27'd0, out_index}, beats);
            check("beat_data", out_data, exp_data[beats]);
          end
        end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ((c % 4) == 0 || (c % 4) == 3) ? 1'b1 : 1'b0;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        start = (spam && (c == 2 || c == 3)) ? 1'b1 : 1'b0;
        pv   = out_valid;
        pacc = out_valid && out_ready;
        pd   = out_data;
        pidx = out_index;
        if (pacc) beats++;
        if (out_valid && !out_ready) stalls++;
        if (inject && !injected && !out_valid && read_reg1 == 5'd4) begin
          @(negedge clk);
          rf[5] = 32'hDEADBEEF;
          injected = 1;
        end
      end
      step();
      c++;
    end
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
    start = 1'b0;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    step();
    check("idle_busy2", {31'd0, busy}, 32'd0);
    check("idle_valid2", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int c, beats;
    bit fin, hit;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    start4 = 1'b0; out_ready_4 = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA5A50000 + i;
    for (int i = 0; i < 4; i++) rf4[i] = $urandom;
    step();
    step();
    check("rst_rr1", {27'd0, read_reg1}, 32'd0);
    check("rst_rr2", {27'd0, read_reg2}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_index", {27'd0, out_index}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // Plain dump, then the same contents under 1,0,0,1 backpressure.
    load_exp();
    do_dump(0, 0, 0);
    do_dump(1, 0, 0);

    // Negedge write during READ of pair (4,5) must land in beat 5.
    load_exp();
    exp_data[5] = 32'hDEADBEEF;
    do_dump(0, 0, 1);

    // Starts while busy and in DONE are ignored; an idle start works again.
    load_exp();
    do_dump(0, 1, 0);
    do_dump(0, 0, 0);

    // Reset while stalled in SEND0 on index 10.
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (out_valid && out_index == 5'd10) hit = 1;
      else step();
    end
    check("rst10_reached", {31'd0, hit}, 32'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    check("rst10_rr1", {27'd0, read_reg1}, 32'd0);
    check("rst10_rr2", {27'd0, read_reg2}, 32'd0);
    check("rst10_data", out_data, 32'd0);
    check("rst10_index", {27'd0, out_index}, 32'd0);
    check("rst10_valid", {31'd0, out_valid}, 32'd0);
    check("rst10_busy", {31'd0, busy}, 32'd0);
    check("rst10_done", {31'd0, done}, 32'd0);
    for (int n = 0; n < 6; n++) begin
      step();
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_done", {31'd0, done}, 32'd0);
    end

    // Random contents under random backpressure.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      load_exp();
      do_dump(2, 0, 0);
    end

    // NUM_REGS=4 instance: beats 0..3, done at T+7.
    start4 = 1'b1; out_ready_4 = 1'b1;
    step();
    start4 = 1'b0;
    c = 1; beats = 0; fin = 0;
    for (int n = 0; n < 50 && !fin; n++) begin
      if (done_4) begin
        check("n4_done_cycle", c, 7);
        check("n4_beats", beats, 4);
        fin = 1;
      end else begin
        if (out_valid_4 && beats < 4) begin
          check("n4_index", {27'd0, out_index_4}, beats);
          check("n4_data", out_data_4, rf4[beats]);
        end
        if (out_valid_4) beats++;
        step();
        c++;
      end
    end
    if (!fin) check("n4_timeout", 32'd0, 32'd1);
    step();
    check("n4_idle_busy", {31'd0, busy_4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential reader for the 32×32 register file: on a start pulse it walks every register index through the register file's two combinational read ports, two registers per access. It streams the contents out one word per beat on a valid/ready interface, tagged with the register index. It sits between the register block and the testbench/debug dump logic, and is the read-side counterpart of the register write path.

## Interface
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1); even, 2..32
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register index width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- read_reg1  output  ADDR_WIDTH  even register index to register file read port 1
- read_reg2  output  ADDR_WIDTH  odd register index to register file read port 2
- read_data1  input  DATA_WIDTH  combinational read data for read_reg1
- read_data2  input  DATA_WIDTH  combinational read data for read_reg2
- out_data  output  DATA_WIDTH  streamed register word
- out_index  output  ADDR_WIDTH  register index of out_data
- out_valid  output  1  out_data/out_index valid
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready at a rising edge
- busy  output  1  high in READ, SEND0 and SEND1
- done  output  1  one-cycle pulse after the last beat is accepted

## Operation
- Clock is clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE, pair counter k=0, read_reg1=0, read_reg2=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0. Capture buffers are cleared to 0.
- All outputs are registered.
- IDLE: if start=1, go to READ with read_reg1=0, read_reg2=1, k=0.
- READ: addresses are stable for the whole cycle.
  - At the next edge, capture read_data1→buf0 and read_data2→buf1.
  - Drive out_data=buf0, out_index=2k, out_valid=1, then go to SEND0.
- SEND0: hold outputs while out_ready=0. On acceptance, out_data=buf1, out_index=2k+1, then go to SEND1.
- SEND1: on acceptance, out_valid=0.
  - If 2k+1 == NUM_REGS-1, go to DONE.
  - Otherwise k=k+1, read_reg1=2k+2, read_reg2=2k+3, then go to READ.
- DONE: done=1, busy=0, out_valid=0 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE, including in DONE; there is no queuing of a second start.
- Coherency: each word is the register file value at its capture edge.
  - This includes any negedge write completed during the READ cycle.
  - No snapshot coherency exists across pairs; the register file is not stalled.
- Reset asserted in any state: next cycle is IDLE with reset values. A partially delivered beat is dropped and done is not pulsed.
- Index arithmetic is ADDR_WIDTH unsigned and never wraps; the last pair is NUM_REGS-2/NUM_REGS-1.

## Timing
- start sampled high at edge T:
  - cycle T+1: READ, busy=1, read_reg1=0, read_reg2=1.
  - cycle T+2: out_valid=1, out_index=0.
- Read latency: 1 cycle from address drive to capture. Each pair costs 3 cycles with out_ready held high.
- Full 32-register dump with out_ready=1:
  - pair k in READ at T+1+3k;
  - last beat (index 31) in cycle T+48;
  - done=1 in cycle T+49;
  - IDLE at T+50, when a new start is sampled.
- Backpressure adds exactly one cycle per cycle that out_ready is low while out_valid is high. out_data and out_index are stable throughout.
- out_valid never drops without acceptance, except on reset.

## Test plan
- Preload register i with 0xA5A50000+i, hold out_ready=1, pulse start → 32 beats indices 0..31 in order with matching data. done in cycle T+49, busy high T+1..T+48.
- Same preload, toggle out_ready 1,0,0,1 repeatedly → identical 32-beat sequence, data stable during stalls, total latency extended by exactly the stalled-valid cycles.
- During READ of pair (4,5), write 0xDEADBEEF to register 5 on the preceding negedge → beat index 5 carries 0xDEADBEEF.
- Pulse start while busy, in SEND1, and in the DONE cycle → ignored. Exactly one dump and one done pulse, then a start in IDLE launches a second dump.
- Assert reset for one cycle while in SEND0 at index 10 with out_ready=0 → next cycle all outputs at reset values, no done, no further beats until a new start.
- NUM_REGS=4 build → beats 0..3, done at T+7.
